// File: rtl/alu_seq.sv
// alu_seq: issue-side sequencer for the 8-bit ALU with a 4x8 register file.
// Define ALU_SEQ_CC_EN to enable COND-driven skip of the next instruction.
module alu_seq #(
  parameter int unsigned DATA_W = 8,
  parameter logic [DATA_W-1:0] REG_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_e,
  input  logic [7:0]        alu_flag,
  output logic              wb_valid,
  output logic [1:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flag_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] wd_q;
  logic [2:0]        op_q;
  logic [1:0]        wa_q;
  logic              ldi_q;
  logic              skip_q;

  logic [1:0]        cls;
  logic [2:0]        op;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] wb_val;
  logic              acc;
  logic              keep;
  logic              go_alu;
  logic              go_ldi;
  logic              unused_flag;

  assign cls = in_instr[15:14];
  assign op  = in_instr[13:11];
  assign rd  = in_instr[10:9];
  assign rs  = in_instr[8:7];
  assign imm = in_instr[DATA_W-1:0];

  assign unused_flag = ^alu_flag[7:3];

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign alu_en   = (state_q == EXEC);
  assign wb_valid = (state_q == WB);

  assign acc    = in_valid & in_ready;
  assign keep   = acc & ~skip_q;
  assign go_alu = keep & ~cls[1];
  assign go_ldi = keep & (cls == 2'b10);

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign wb_addr = wa_q;
  assign wb_val  = ldi_q ? wd_q : alu_e;
  assign wb_data = wb_valid ? wb_val : wd_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ALU classes pass through EXEC, LDI goes to WB, COND stays.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          go_alu:  state_d = EXEC;
          go_ldi:  state_d = WB;
          default: state_d = IDLE;
        endcase
      end
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands latch at issue; register file and flags update as WB ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= REG_INIT;
      end
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      wa_q   <= '0;
      wd_q   <= '0;
      ldi_q  <= 1'b0;
      flag_q <= '0;
    end else begin
      if (go_alu) begin
        a_q   <= rf_q[rd];
        b_q   <= cls[0] ? imm : rf_q[rs];
        op_q  <= op;
        wa_q  <= rd;
        ldi_q <= 1'b0;
      end
      if (go_ldi) begin
        wa_q  <= rd;
        wd_q  <= imm;
        ldi_q <= 1'b1;
      end
      if (wb_valid) begin
        rf_q[wa_q] <= wb_val;
        wd_q       <= wb_val;
        if (!ldi_q) begin
          flag_q <= alu_flag[2:0];
        end
      end
    end
  end

`ifdef ALU_SEQ_CC_EN
  logic       go_cnd;
  logic [3:0] cc;

  assign go_cnd = keep & (cls == 2'b11);
  assign cc     = {1'b1, flag_q};

  // Skip arms on COND and is consumed by the next accepted instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_q <= 1'b0;
    end else if (acc && skip_q) begin
      skip_q <= 1'b0;
    end else if (go_cnd) begin
      skip_q <= cc[in_instr[12:11]] ^ in_instr[13];
    end
  end
`else
  assign skip_q = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random instruction streams for alu_seq.
// A transaction-level model predicts handshake, ALU drive and writeback.
`timescale 1ns/1ps
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic [7:0]  alu_a, alu_b, alu_e, alu_flag, wb_data;
  logic [2:0]  alu_op, flag_q;
  logic        alu_en, wb_valid, busy;
  logic [1:0]  wb_addr;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_en(alu_en), .alu_e(alu_e), .alu_flag(alu_flag),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_q(flag_q), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_en = 0;
  int n_wb = 0;
  int acc_cyc = 0;
  logic [7:0] last_data = '0;
  logic [1:0] last_addr = '0;

  // Reference ALU: returns {carry, result}.
  function automatic logic [8:0] alu_f(input logic [2:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {a < b, a - b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, ~a};
      3'd5: r = {1'b0, a ^ b};
      3'd6: r = (b >= 8'd8) ? 9'd0 : {1'b0, a << b};
      default: r = (b >= 8'd8) ? 9'd0 : {1'b0, a >> b};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] flg(input logic [8:0] r);
    return {r[8], r[7], r[7:0] == 8'h00};
  endfunction

  // Environment ALU: result combinational, flags latched on negedge with alu_en.
  logic [2:0] alu_fl_q = '0;
  logic [8:0] alu_r;
  always_comb begin
    alu_r    = alu_f(alu_op, alu_a, alu_b);
    alu_e    = alu_r[7:0];
    alu_flag = {5'b0, alu_fl_q};
  end
  always @(negedge clk) if (alu_en) alu_fl_q <= flg(alu_r);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state.
  logic [7:0] m_rf [4];
  logic [2:0] m_flag;
  bit         m_skip;
  int         rem;
  bit         p_alu;
  logic [1:0] p_addr;
  logic [7:0] p_data, x_a, x_b;
  logic [2:0] p_flag, x_op;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_flag = '0;
    m_skip = 1'b0;
    rem    = 0;
    p_alu  = 1'b0;
  endtask

  task automatic m_accept(input logic [15:0] w);
    logic [1:0] cls, rd, rs;
    logic [2:0] op;
    logic [7:0] imm, b;
    logic [8:0] r;
`ifdef ALU_SEQ_CC_EN
    logic [3:0] cc;
`endif
    cls = w[15:14];
    op  = w[13:11];
    rd  = w[10:9];
    rs  = w[8:7];
    imm = w[7:0];
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    if (cls == 2'b10) begin
      p_alu  = 1'b0;
      p_addr = rd;
      p_data = imm;
      rem    = 1;
    end else if (cls == 2'b11) begin
`ifdef ALU_SEQ_CC_EN
      cc     = {1'b1, m_flag};
      m_skip = cc[w[12:11]] ^ w[13];
`endif
    end else begin
      b      = cls[0] ? imm : m_rf[rs];
      r      = alu_f(op, m_rf[rd], b);
      p_alu  = 1'b1;
      p_addr = rd;
      p_data = r[7:0];
      p_flag = flg(r);
      x_a    = m_rf[rd];
      x_b    = b;
      x_op   = op;
      rem    = 2;
    end
  endtask

  // Model update at each posedge; async reset clears it at once.
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else if (rem > 0) begin
        if (rem == 1) begin
          m_rf[p_addr] = p_data;
          if (p_alu) m_flag = p_flag;
        end
        rem--;
      end else if (in_valid) begin
        m_accept(in_instr);
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, rem == 0);
      chk("busy", busy, rem != 0);
      chk("alu_en", alu_en, rem == 2);
      chk("wb_valid", wb_valid, rem == 1);
      chk("flag_q", flag_q, m_flag);
      if (rem == 1) begin
        chk("wb_addr", wb_addr, p_addr);
        chk("wb_data", wb_data, p_data);
      end
      if (rem != 0 && p_alu) begin
        chk("alu_a", alu_a, x_a);
        chk("alu_b", alu_b, x_b);
        chk("alu_op", alu_op, x_op);
      end
      if (alu_en) n_en++;
      if (wb_valid) begin
        n_wb++;
        last_data = wb_data;
        last_addr = wb_addr;
      end
    end
  end

  function automatic logic [15:0] rr(input logic [2:0] op,
                                     input logic [1:0] d,
                                     input logic [1:0] s);
    return {2'b00, op, d, s, 7'b0};
  endfunction

  function automatic logic [15:0] ri(input logic [2:0] op,
                                     input logic [1:0] d,
                                     input logic [7:0] im);
    return {2'b01, op, d, 1'b0, im};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] d,
                                      input logic [7:0] im);
    return {2'b10, 3'b000, d, 1'b0, im};
  endfunction

  function automatic logic [15:0] cnd(input logic pol,
                                      input logic [1:0] idx);
    return {2'b11, pol, idx, 11'b0};
  endfunction

  task automatic issue(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    chk("accept", ok, 1);
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int  c0, c1, c2, e0, w0;
  bit  seen;

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_alu_op", alu_op, 3'b000);
    chk("rst_wb_data", wb_data, 8'h00);
    chk("rst_wb_addr", wb_addr, 2'd0);
    rst_n = 1'b1;
    idle(1);

    // T1
    issue(ldi(2'd0, 8'h05));
    issue(ldi(2'd1, 8'h03));
    issue(rr(3'd0, 2'd0, 2'd1));
    idle(4);
    chk("t1_data", last_data, 8'h08);
    chk("t1_addr", last_addr, 2'd0);
    chk("t1_flag", flag_q, 3'b000);

    // T2
    issue(ldi(2'd0, 8'hFF));
    idle(3);
    e0 = n_en;
    issue(ri(3'd0, 2'd0, 8'h01));
    idle(4);
    chk("t2_data", last_data, 8'h00);
    chk("t2_flag", flag_q, 3'b101);
    chk("t2_en_pulses", n_en - e0, 1);

    // T3
    w0 = n_wb;
    issue(rr(3'd0, 2'd1, 2'd0));
    c0 = acc_cyc;
    issue(ri(3'd5, 2'd2, 8'h0F));
    c1 = acc_cyc;
    issue(ri(3'd1, 2'd3, 8'h01));
    c2 = acc_cyc;
    idle(4);
    chk("t3_gap1", c1 - c0, 3);
    chk("t3_gap2", c2 - c1, 3);
    chk("t3_wb_count", n_wb - w0, 3);
    chk("t3_data", last_data, 8'hFF);
    chk("t3_addr", last_addr, 2'd3);
    chk("t3_flag", flag_q, 3'b110);

    // Shift amount past width, and rd==rs.
    issue(ldi(2'd0, 8'h81));
    issue(ri(3'd6, 2'd0, 8'd9));
    idle(4);
    chk("shl9_data", last_data, 8'h00);
    chk("shl9_flag", flag_q, 3'b001);
    issue(ldi(2'd1, 8'h07));
    issue(rr(3'd0, 2'd1, 2'd1));
    idle(4);
    chk("rdrs_data", last_data, 8'h0E);

`ifdef ALU_SEQ_CC_EN
    // T4
    issue(ri(3'd2, 2'd0, 8'h00));
    idle(4);
    w0 = n_wb;
    issue(cnd(1'b0, 2'd0));
    issue(ldi(2'd2, 8'h55));
    idle(3);
    chk("t4_no_wb", n_wb - w0, 0);
    issue(ri(3'd3, 2'd2, 8'h00));
    idle(4);
    chk("t4_r2", last_data, 8'h0F);
    // T5
    w0 = n_wb;
    issue(cnd(1'b0, 2'd3));
    issue(cnd(1'b1, 2'd0));
    issue(ldi(2'd3, 8'hAA));
    idle(3);
    chk("t5_wb", n_wb - w0, 1);
    chk("t5_data", last_data, 8'hAA);
    chk("t5_addr", last_addr, 2'd3);
`else
    w0 = n_wb;
    issue(cnd(1'b0, 2'd3));
    issue(ldi(2'd2, 8'h55));
    idle(3);
    chk("nop_wb", n_wb - w0, 1);
    chk("nop_data", last_data, 8'h55);
    chk("nop_addr", last_addr, 2'd2);
`endif

    // T6
    issue(rr(3'd1, 2'd1, 2'd0));
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = wb_valid;
    end
    chk("t6_wb_seen", seen, 1);
    #2 rst_n = 1'b0;
    w0 = n_wb;
    repeat (2) @(negedge clk);
    #2;
    chk("t6_flag", flag_q, 3'b000);
    chk("t6_no_wb", n_wb - w0, 0);
    rst_n = 1'b1;
    #1;
    chk("t6_ready", in_ready, 1);
    idle(1);
    for (int r = 0; r < 4; r++) begin
      issue(ri(3'd3, 2'(r), 8'h00));
      idle(4);
      chk("t6_reg", last_data, 8'h00);
    end

    // Random stream.
    for (int k = 0; k < 300; k++) begin
      issue(16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
